// File: rtl/id_stage.sv
// id_stage: MIPS decode stage, turns in_instr plus register-file reads into the ID/EX register feeding the ALU.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_*; rf_rdata is sampled in the accept cycle.
// Backpressure: out_* hold while out_valid && !ex_ready; load-use inserts one bubble; flush kills the stage.
// Build option: define DECODE_ILLEGAL_TRAP_EN to flag unsupported opcodes/functs on out_illegal
// (otherwise they decode as a NOP and out_illegal stays 0).
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_v1,
    output logic [31:0] out_v2,
    output logic        out_wr_en,
    output logic [4:0]  out_wr_addr,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic [31:0] out_store_data,
    output logic        out_illegal
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU op encodings (unsigned add/sub share the signed codes)
    localparam logic [3:0] ALU_ADD = 4'b1100;
    localparam logic [3:0] ALU_SUB = 4'b1110;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1011;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b1111;

    // Contents of the ID/EX register
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [3:0]  alu_op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store_data;
    } idex_t;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] simm;
    logic [31:0] zimm;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign shamt  = in_instr[10:6];
    assign funct  = in_instr[5:0];
    assign simm   = {{16{in_instr[15]}}, in_instr[15:0]};
    assign zimm   = {16'h0000, in_instr[15:0]};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    idex_t      dec;
    idex_t      stage_d;
    idex_t      stage_q;
    logic       legal;
    logic       writes;
    logic [4:0] dest;
    logic       use_rs;
    logic       use_rt;
    logic       advance;
    logic       hazard;
    logic       accept;

    // Decode in_instr and the same-cycle register reads into an ID/EX image
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.v1    = rf_rdata1;
        legal     = 1'b1;
        writes    = 1'b1;
        dest      = rt;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                dest   = rd;
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec.v2 = rf_rdata2;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // fixed shifts take the amount from the instruction, not rs
                        dec.alu_op = {2'b00, funct[1:0]};
                        dec.v1     = {27'b0, shamt};
                        use_rs     = 1'b0;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: dec.alu_op = {2'b00, funct[1:0]};
                    FN_ADD, FN_ADDU:           dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU:           dec.alu_op = ALU_SUB;
                    FN_AND:                    dec.alu_op = ALU_AND;
                    FN_OR:                     dec.alu_op = ALU_OR;
                    FN_XOR:                    dec.alu_op = ALU_XOR;
                    FN_NOR:                    dec.alu_op = ALU_NOR;
                    FN_SLT:                    dec.alu_op = ALU_SLT;
                    default:                   legal      = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_ADDIU: begin
                dec.alu_op = ALU_ADD;
                dec.v2     = simm;
                use_rs     = 1'b1;
            end
            OPC_SLTI: begin
                dec.alu_op = ALU_SLT;
                dec.v2     = simm;
                use_rs     = 1'b1;
            end
            OPC_ANDI: begin
                dec.alu_op = ALU_AND;
                dec.v2     = zimm;
                use_rs     = 1'b1;
            end
            OPC_ORI: begin
                dec.alu_op = ALU_OR;
                dec.v2     = zimm;
                use_rs     = 1'b1;
            end
            OPC_XORI: begin
                dec.alu_op = ALU_XOR;
                dec.v2     = zimm;
                use_rs     = 1'b1;
            end
            OPC_LUI: begin
                // ALU passes v2 straight through
                dec.alu_op = ALU_LUI;
                dec.v1     = 32'h0;
                dec.v2     = {in_instr[15:0], 16'h0000};
            end
            OPC_LW: begin
                dec.alu_op = ALU_ADD;
                dec.v2     = simm;
                dec.mem_rd = 1'b1;
                use_rs     = 1'b1;
            end
            OPC_SW: begin
                dec.alu_op     = ALU_ADD;
                dec.v2         = simm;
                dec.mem_wr     = 1'b1;
                dec.store_data = rf_rdata2;
                writes         = 1'b0;
                use_rs         = 1'b1;
                use_rt         = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.wr_addr = dest;
        // writes to $0 are discarded, which makes 0x00000000 a NOP
        dec.wr_en   = writes && (dest != 5'd0);
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = TRAP_EN;
            use_rs      = 1'b0;
            use_rt      = 1'b0;
        end
    end

    // A load in ID/EX cannot forward its data to the instruction behind it
    assign advance  = !stage_q.valid || ex_ready;
    assign hazard   = stage_q.valid && stage_q.mem_rd && stage_q.wr_en &&
                      ((use_rs && (rs == stage_q.wr_addr)) ||
                       (use_rt && (rt == stage_q.wr_addr)));
    assign in_ready = advance && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Next ID/EX contents: flush beats hold, hold beats load; empty slots are all-zero bubbles
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (advance) begin
            stage_d = accept ? dec : '0;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid      = stage_q.valid;
    assign out_illegal    = stage_q.illegal;
    assign out_alu_op     = stage_q.alu_op;
    assign out_v1         = stage_q.v1;
    assign out_v2         = stage_q.v2;
    assign out_wr_en      = stage_q.wr_en;
    assign out_wr_addr    = stage_q.wr_addr;
    assign out_mem_rd     = stage_q.mem_rd;
    assign out_mem_wr     = stage_q.mem_wr;
    assign out_store_data = stage_q.store_data;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed + randomized checks of id_stage against a mnemonic-level reference model.
// Latency: model advances once per clock; outputs compared half a cycle after each rising edge.
// Backpressure: random ex_ready / flush / in_valid drive holds, bubbles and load-use stalls.
module tb_id_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        flush;
    logic        ex_ready;
    logic        out_valid;
    logic [3:0]  out_alu_op;
    logic [31:0] out_v1;
    logic [31:0] out_v2;
    logic        out_wr_en;
    logic [4:0]  out_wr_addr;
    logic        out_mem_rd;
    logic        out_mem_wr;
    logic [31:0] out_store_data;
    logic        out_illegal;

    logic [31:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid), .out_alu_op(out_alu_op),
        .out_v1(out_v1), .out_v2(out_v2), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
        .out_illegal(out_illegal)
    );

    typedef enum int {
        K_SLL, K_SRL, K_SRA, K_SLLV, K_SRLV, K_SRAV, K_ADD, K_ADDU, K_SUB, K_SUBU,
        K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_ADDI, K_ADDIU, K_SLTI, K_ANDI, K_ORI,
        K_XORI, K_LUI, K_LW, K_SW, K_BAD
    } kind_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store;
    } st_t;

    int   checks = 0;
    int   errors = 0;
    st_t  m;
    logic last_rdy;
    logic exp_rdy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] i);
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h00: return K_SLL;   6'h02: return K_SRL;   6'h03: return K_SRA;
                6'h04: return K_SLLV;  6'h06: return K_SRLV;  6'h07: return K_SRAV;
                6'h20: return K_ADD;   6'h21: return K_ADDU;  6'h22: return K_SUB;
                6'h23: return K_SUBU;  6'h24: return K_AND;   6'h25: return K_OR;
                6'h26: return K_XOR;   6'h27: return K_NOR;   6'h2A: return K_SLT;
                default: return K_BAD;
            endcase
        end
        case (i[31:26])
            6'h08: return K_ADDI;  6'h09: return K_ADDIU; 6'h0A: return K_SLTI;
            6'h0C: return K_ANDI;  6'h0D: return K_ORI;   6'h0E: return K_XORI;
            6'h0F: return K_LUI;   6'h23: return K_LW;    6'h2B: return K_SW;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input kind_t k);
        case (k)
            K_SLL, K_SLLV:                          return 4'b0000;
            K_SRL, K_SRLV:                          return 4'b0010;
            K_SRA, K_SRAV:                          return 4'b0011;
            K_ADD, K_ADDU, K_ADDI, K_ADDIU, K_LW, K_SW: return 4'b1100;
            K_SUB, K_SUBU:                          return 4'b1110;
            K_AND, K_ANDI:                          return 4'b1000;
            K_OR, K_ORI:                            return 4'b1001;
            K_XOR, K_XORI:                          return 4'b1010;
            K_NOR:                                  return 4'b1011;
            K_SLT, K_SLTI:                          return 4'b0110;
            K_LUI:                                  return 4'b1111;
            default:                                return 4'b0000;
        endcase
    endfunction

    // Does instruction i read register r (for interlock purposes)?
    function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
        kind_t k = kind_of(i);
        logic rs_hit = (i[25:21] == r);
        logic rt_hit = (i[20:16] == r);
        case (k)
            K_SLL, K_SRL, K_SRA:                     return rt_hit;
            K_SLLV, K_SRLV, K_SRAV, K_ADD, K_ADDU, K_SUB, K_SUBU,
            K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SW:   return rs_hit || rt_hit;
            K_LUI, K_BAD:                            return 1'b0;
            default:                                 return rs_hit;
        endcase
    endfunction

    function automatic st_t ref_decode(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        st_t         s = '0;
        kind_t       k = kind_of(i);
        logic [31:0] sx = {{16{i[15]}}, i[15:0]};
        logic [31:0] zx = 32'(i[15:0]);
        logic [4:0]  dst;
        s.valid = 1'b1;
        if (k == K_BAD) begin
            s.illegal = TRAP;
            return s;
        end
        s.op = alu_of(k);
        dst  = (i[31:26] == 6'h00) ? i[15:11] : i[20:16];
        case (k)
            K_SLL, K_SRL, K_SRA:          begin s.v1 = 32'(i[10:6]); s.v2 = b; end
            K_ADDI, K_ADDIU, K_SLTI, K_LW: begin s.v1 = a; s.v2 = sx; end
            K_ANDI, K_ORI, K_XORI:        begin s.v1 = a; s.v2 = zx; end
            K_LUI:                        begin s.v1 = 0; s.v2 = zx * 32'h10000; end
            K_SW:                         begin s.v1 = a; s.v2 = sx; s.store = b; end
            default:                      begin s.v1 = a; s.v2 = b; end
        endcase
        s.wr_addr = dst;
        s.wr_en   = (k != K_SW) && (dst != 0);
        s.mem_rd  = (k == K_LW);
        s.mem_wr  = (k == K_SW);
        return s;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x = $urandom;
        int          sel = $urandom_range(0, 27);
        x[25:21] = 5'($urandom_range(0, 7));
        x[20:16] = 5'($urandom_range(0, 7));
        x[15:11] = 5'($urandom_range(0, 7));
        if (sel < 16) begin
            x[31:26] = 6'h00;
            case (sel)
                0: x[5:0] = 6'h00;  1: x[5:0] = 6'h02;  2: x[5:0] = 6'h03;  3: x[5:0] = 6'h04;
                4: x[5:0] = 6'h06;  5: x[5:0] = 6'h07;  6: x[5:0] = 6'h20;  7: x[5:0] = 6'h21;
                8: x[5:0] = 6'h22;  9: x[5:0] = 6'h23; 10: x[5:0] = 6'h24; 11: x[5:0] = 6'h25;
               12: x[5:0] = 6'h26; 13: x[5:0] = 6'h27; 14: x[5:0] = 6'h2A;
                default: x[5:0] = 6'h2B;
            endcase
        end else begin
            case (sel)
                16: x[31:26] = 6'h08; 17: x[31:26] = 6'h09; 18: x[31:26] = 6'h0A;
                19: x[31:26] = 6'h0C; 20: x[31:26] = 6'h0D; 21: x[31:26] = 6'h0E;
                22: x[31:26] = 6'h0F; 23: x[31:26] = 6'h2B; 24: x[31:26] = 6'h3F;
                default: x[31:26] = 6'h23;
            endcase
        end
        return x;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".valid"},   out_valid,      m.valid);
        check_val({tag, ".illegal"}, out_illegal,    m.illegal);
        check_val({tag, ".op"},      out_alu_op,     m.op);
        check_val({tag, ".v1"},      out_v1,         m.v1);
        check_val({tag, ".v2"},      out_v2,         m.v2);
        check_val({tag, ".wr_en"},   out_wr_en,      m.wr_en);
        check_val({tag, ".wr_addr"}, out_wr_addr,    m.wr_addr);
        check_val({tag, ".mem_rd"},  out_mem_rd,     m.mem_rd);
        check_val({tag, ".mem_wr"},  out_mem_wr,     m.mem_wr);
        check_val({tag, ".store"},   out_store_data, m.store);
    endtask

    // Entered at a falling edge: drive, check combinational outputs, clock once, check registers.
    task automatic do_cycle(input string tag, input logic v, input logic [31:0] ins,
                            input logic er, input logic fl);
        st_t  nxt;
        logic adv;
        logic haz;
        in_valid = v;
        in_instr = ins;
        ex_ready = er;
        flush    = fl;
        #1;
        adv     = !m.valid || er;
        haz     = m.valid && m.mem_rd && m.wr_en && reads(ins, m.wr_addr);
        exp_rdy = adv && !haz && !fl;
        last_rdy = in_ready;
        check_val({tag, ".in_ready"}, in_ready, exp_rdy);
        check_val({tag, ".raddr1"}, rf_raddr1, ins[25:21]);
        check_val({tag, ".raddr2"}, rf_raddr2, ins[20:16]);
        if (fl)                nxt = '0;
        else if (!adv)         nxt = m;
        else if (v && exp_rdy) nxt = ref_decode(ins, regs[ins[25:21]], regs[ins[20:16]]);
        else                   nxt = '0;
        @(posedge clk);
        m = nxt;
        @(negedge clk);
        check_outputs(tag);
    endtask

    logic [31:0] cur;
    logic        rv;
    logic        rer;
    logic        rfl;

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : $urandom;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0; ex_ready = 1'b1;
        m = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset");
        check_val("reset.in_ready", in_ready, 1'b1);
        @(negedge clk);
        do_cycle("idle", 1'b0, 32'h0, 1'b1, 1'b0);

        // addu $3,$1,$2
        regs[1] = 32'd5; regs[2] = 32'd7;
        do_cycle("addu", 1'b1, 32'h00221821, 1'b1, 1'b0);
        check_val("addu.op_const", out_alu_op, 4'b1100);
        check_val("addu.v1_const", out_v1, 32'd5);
        check_val("addu.v2_const", out_v2, 32'd7);
        check_val("addu.wa_const", out_wr_addr, 5'd3);

        // lw $4,8($1) then dependent add $5,$4,$2: one bubble
        do_cycle("lw", 1'b1, 32'h8C240008, 1'b1, 1'b0);
        do_cycle("lu_stall", 1'b1, 32'h00822820, 1'b1, 1'b0);
        check_val("lu_stall.rdy_const", last_rdy, 1'b0);
        check_val("lu_stall.bubble", out_valid, 1'b0);
        do_cycle("lu_go", 1'b1, 32'h00822820, 1'b1, 1'b0);
        check_val("lu_go.rdy_const", last_rdy, 1'b1);
        check_val("lu_go.op_const", out_alu_op, 4'b1100);

        // EX back-pressure for 3 cycles
        for (int i = 0; i < 3; i++) do_cycle("hold", 1'b1, 32'h00221821, 1'b0, 1'b0);
        do_cycle("resume", 1'b1, 32'h00221821, 1'b1, 1'b0);

        // flush with a valid instruction, then re-present it
        do_cycle("flush", 1'b1, 32'h3C071234, 1'b1, 1'b1);
        do_cycle("post_flush", 1'b1, 32'h3C071234, 1'b1, 1'b0);
        check_val("lui.op_const", out_alu_op, 4'b1111);
        check_val("lui.v2_const", out_v2, 32'h12340000);

        // slti $2,$1,-1
        do_cycle("slti", 1'b1, 32'h2822FFFF, 1'b1, 1'b0);
        check_val("slti.v2_const", out_v2, 32'hFFFFFFFF);

        // opcode 0x3F
        do_cycle("opc3f", 1'b1, 32'hFC000000, 1'b1, 1'b0);
        check_val("opc3f.illegal", out_illegal, TRAP);
        check_val("opc3f.wr_en", out_wr_en, 1'b0);

        // randomized traffic
        cur = rand_instr();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 7)] = $urandom;
            rv  = ($urandom_range(0, 3) != 0);
            rer = ($urandom_range(0, 3) != 0);
            rfl = ($urandom_range(0, 19) == 0);
            do_cycle("rand", rv, cur, rer, rfl);
            if (rv && exp_rdy) cur = rand_instr();
        end

        // asynchronous reset while stalled
        do_cycle("pre_rst", 1'b1, 32'h00221821, 1'b1, 1'b0);
        in_valid = 1'b1; ex_ready = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m = '0;
        check_outputs("mid_rst");
        check_val("mid_rst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle("after_rst", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the MIPS pipeline: accepts fetched instructions over a valid/ready handshake and reads operands from the register file. It decodes each instruction into the 4-bit ALU op encoding and the two 32-bit ALU operands, and registers everything into the ID/EX pipeline register feeding the ALU. It also owns load-use interlock (one-bubble insertion), back-pressure from EX, and pipeline flush.

## Interface
- Parameters: none; datapath fixed at 32 bits, register addresses 5 bits.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_instr valid
- in_ready  out  1  instruction consumed on in_valid && in_ready
- in_instr  in  32  MIPS instruction word
- rf_raddr1 / rf_raddr2  out  5  combinational rs / rt
- rf_rdata1 / rf_rdata2  in  32  same-cycle read data
- flush  in  1  synchronous kill of stage contents
- ex_ready  in  1  EX accepts out_* this cycle
- out_valid  out  1  ID/EX register holds an instruction
- out_alu_op  out  4  ALU op code
- out_v1 / out_v2  out  32  ALU operands
- out_wr_en / out_wr_addr  out  1 / 5  register writeback
- out_mem_rd / out_mem_wr  out  1  load / store
- out_store_data  out  32  rt value for sw
- out_illegal  out  1  unsupported instruction (see Configuration)

## Operation
- ALU codes: sll 0000, srl 0010, sra 0011, add/addu/addi/addiu/lw/sw 1100, sub/subu 1110, and/andi 1000, or/ori 1001, xor/xori 1010, nor 1011, slt/slti 0110, lui 1111 (pass v2). addu/subu map to 1100/1110, never 1101/1111.
- R-type fixed shifts: v1={27'b0,shamt}, v2=rt. Variable shifts (sllv/srlv/srav): op={2'b00,funct[1:0]}, v1=rs[31:0], v2=rt. Other R-type: v1=rs, v2=rt. Destination rd.
- I-type: v1=rs, destination rt. addi/addiu/slti/lw/sw sign-extend imm; andi/ori/xori zero-extend. lui: v1=0, v2={imm,16'b0}.
- lw: mem_rd=1. sw: mem_wr=1, wr_en=0, store_data=rt.
- wr_en forced 0 when destination is $0; 0x00000000 is therefore a NOP.
- Register usage for hazard: R-type uses rs and rt (fixed shifts use rt only); I-type ALU and lw use rs; sw uses rs and rt; lui uses none.
- advance = !out_valid || ex_ready.
- hazard = out_valid && out_mem_rd && out_wr_en && out_wr_addr equals a used source of in_instr.
- in_ready = advance && !hazard && !flush.
- On advance, the register loads the decoded in_instr if in_valid && in_ready; otherwise it loads a bubble (out_valid=0).
- Priority: reset > flush > hold (!advance) > load.

## Timing
- Reset: out_valid=0 and all out_* = 0; in_ready=1 after release.
- Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N; rf_rdata is sampled in the accept cycle.
- Hold: while out_valid && !ex_ready, all out_* remain stable and in_ready=0.
- Load-use: exactly one bubble; the dependent instruction is accepted the following cycle.
- Flush: out_valid=0 after the edge and in_instr is not consumed. flush overrides hold.
- Reset asserted mid-stall clears the stage immediately; no instruction survives.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: an unsupported opcode or funct sets out_illegal=1 with out_valid=1, wr_en=0 and mem_rd/mem_wr=0.
- Not defined: out_illegal is tied 0, and unsupported instructions decode as a NOP (op 0000, v1=v2=0, wr_en=0).

## Test plan
- Reset, then release with in_valid=0 -> out_valid=0, in_ready=1, all out_*=0.
- 0x00221821 (addu $3,$1,$2), rdata1=5, rdata2=7 -> next cycle out_alu_op=1100, v1=5, v2=7, wr_addr=3, wr_en=1.
- 0x8C240008 (lw $4,8($1)) then 0x00822820 (add $5,$4,$2) back-to-back -> in_ready=0 for one cycle, one bubble, add emitted the cycle after, op=1100.
- ex_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; resumes on the cycle ex_ready returns high.
- flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, instruction re-presented and accepted afterward.
- 0x3C071234 (lui $7,0x1234) -> op=1111, v2=0x12340000. slti with imm 0xFFFF -> v2=0xFFFFFFFF. Opcode 0x3F -> out_illegal=1 only with DECODE_ILLEGAL_TRAP_EN.
